pb_debouncer: RTL
=================

Name: pb_debouncer

Overview:
- Upstream conditioning stage for the up/down counter in the traffic-light design.
- Takes a raw, bouncing push-button input and synchronises it to clk.
- Rejects bounce and glitches shorter than a programmable window.
- Emits clean one-cycle press/release strobes, plus an active-low strobe (pb_n) that drives the counter's negedge-triggered pb input directly.

Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable synchronised samples required beyond the first (10 ms at 50 MHz); must be >= 1. Counter width is a localparam, $clog2(DEBOUNCE_CYCLES)+1.
- ACTIVE_LOW, default 1: 1 means pb_in=0 is "pressed" (board KEYs); 0 means pb_in=1 is "pressed".
- REPEAT_DELAY, default 25000000: cycles in HELD before the first auto-repeat strobe. Used only with AUTOREPEAT_EN.
- REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat strobes. Used only with AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- pb_in  input  1  raw asynchronous button level.
- pb_level  output  1  debounced level, 1 = pressed.
- press_pulse  output  1  one-cycle strobe on an accepted press (and on each auto-repeat).
- release_pulse  output  1  one-cycle strobe on an accepted release.
- pb_n  output  1  equals ~press_pulse; idles 1 and goes low one cycle per press, feeding the counter's pb.

Behaviour:
- Synchroniser: two flops on pb_in, followed by polarity normalisation to pb_sync (1 = pressed). Reset loads the flops with the released value.
- Reset, taking effect at the next posedge with rst=1:
  - state=IDLE, debounce counter=0.
  - pb_level=0, press_pulse=0, release_pulse=0, pb_n=1.
  - A reset that arrives mid-debounce or mid-hold discards all progress.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - pb_sync=1 → PRESS_WAIT with cnt=0.
  - Otherwise stay.
- PRESS_WAIT:
  - pb_sync=0 → IDLE. No strobe; the glitch is rejected.
  - pb_sync=1 and cnt==DEBOUNCE_CYCLES-1 → HELD.
  - Otherwise cnt+1.
- HELD:
  - pb_sync=0 → RELEASE_WAIT with cnt=0.
- RELEASE_WAIT:
  - pb_sync=1 → HELD. No strobe.
  - pb_sync=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE.
  - Otherwise cnt+1.
- Output timing (all outputs registered, no combinational path from pb_in):
  - press_pulse is 1 exactly in the first cycle in HELD entered from PRESS_WAIT.
  - release_pulse is 1 exactly in the first cycle in IDLE entered from RELEASE_WAIT.
  - pb_level is 1 in HELD and RELEASE_WAIT.
  - Re-entry to HELD from RELEASE_WAIT produces no press_pulse.
- Latency and acceptance: if edge e is the first edge at which the input flop samples "pressed" and the input stays pressed, press_pulse is high in the cycle after edge e+DEBOUNCE_CYCLES+2. The release path has symmetric latency. Acceptance requires DEBOUNCE_CYCLES+1 consecutive stable pb_sync samples.
- press_pulse and release_pulse are never high in the same cycle; a minimum of DEBOUNCE_CYCLES+1 cycles separates them.
- If the button is held through reset, the press is re-debounced after rst falls and is reported as a new press.
- Counters saturate logically: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.

Optional Feature:
- Macro: PB_DEBOUNCER_AUTOREPEAT_EN
- Defined:
  - A repeat counter runs while in HELD, cleared on entry to HELD.
  - First extra press_pulse (and pb_n low) after REPEAT_DELAY cycles in HELD, then one every REPEAT_PERIOD cycles.
  - Leaving HELD (to RELEASE_WAIT) or rst stops repeats and clears the repeat counter. Returning to HELD from RELEASE_WAIT restarts the REPEAT_DELAY count.
- Undefined:
  - Exactly one press_pulse per accepted press.
  - No repeat counter hardware; REPEAT_* parameters are ignored.

Test Plan:
(DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
- Reset: rst=1 for 3 cycles with pb_in=1 or pb_in=0 → pb_level=0, press_pulse=0, release_pulse=0, pb_n=1 after the first reset edge.
- Clean press: pb_in 1→0 held 20 cycles → press_pulse and pb_n low for exactly 1 cycle, in the cycle after edge e+6; pb_level=1 from that cycle onward; no further strobes.
- Bounce/glitch:
  - pb_in toggles every 2 cycles for 16 cycles, then returns to 1 → zero strobes, pb_level stays 0.
  - From HELD, a 3-cycle pulse of pb_in=1 → no release_pulse, pb_level stays 1.
- Release: from HELD, pb_in 0→1 held 20 cycles → release_pulse high exactly 1 cycle, in the cycle after edge e+6; pb_level falls that same cycle; pb_n remains 1.
- Reset mid-operation: rst=1 for 1 cycle while in PRESS_WAIT with cnt=2, button still held → outputs reset; press_pulse occurs once, 7 cycles after the first non-reset edge.
- Autorepeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=5): hold pressed 40 cycles → press_pulse at HELD entry, then 10, 15, 20, 25 and 30 cycles later; no repeats after release is accepted.

Source files
------------

// File: rtl/pb_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, registered press/release strobes.
// Define PB_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat press strobes while the button is held.
module pb_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pb_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic pb_n
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic IDLE_LVL = ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("pb_debouncer: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             pb_sync;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pb_n_q, pb_n_d;

`ifdef PB_DEBOUNCER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_done_q, rpt_done_d;
    logic [RPT_W-1:0] rpt_last;
`endif

    assign pb_sync = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pb_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pb_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pb_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // Bouncing back to pressed re-enters HELD silently
                if (pb_sync) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef PB_DEBOUNCER_AUTOREPEAT_EN
        // Counter only survives while staying in HELD; any entry or exit clears it
        rpt_last   = rpt_done_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
        rpt_d      = '0;
        rpt_done_d = 1'b0;
        if (state_q == HELD && state_d == HELD) begin
            if (rpt_q == rpt_last) begin
                press_d    = 1'b1;
                rpt_done_d = 1'b1;
            end else begin
                rpt_d      = rpt_q + 1'b1;
                rpt_done_d = rpt_done_q;
            end
        end
`endif

        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        pb_n_d  = ~press_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= IDLE_LVL;
            sync2_q   <= IDLE_LVL;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            pb_n_q    <= 1'b1;
`ifdef PB_DEBOUNCER_AUTOREPEAT_EN
            rpt_q      <= '0;
            rpt_done_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= pb_in;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            pb_n_q    <= pb_n_d;
`ifdef PB_DEBOUNCER_AUTOREPEAT_EN
            rpt_q      <= rpt_d;
            rpt_done_q <= rpt_done_d;
`endif
        end
    end

    assign pb_level      = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign pb_n          = pb_n_q;

endmodule
